// File: rtl/bus_slave_port.sv
// Serial bus slave endpoint: deserialises a 15-bit LSB-first address, acknowledges
// transactions addressed to SLAVE_ID, then commits an 8-bit write or serialises read data.
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   ST_IDLE      | waiting for B_UTIL; first active cycle carries addr[0]
//   ST_ADDRESS   | shifting in addr[1]..addr[14]
//   ST_ACKN      | single ACK cycle; read data is fetched from memory here
//   ST_WRITE     | sampling 8 write-data bits, LSB first
//   ST_READ      | driving 8 read-data bits, LSB first
//   ST_WAIT_IDLE | ignoring the rest of the transaction until B_UTIL drops
module bus_slave_port #(
    parameter logic [2:0]  SLAVE_ID  = 3'd1,
    parameter int unsigned MEM_DEPTH = 2048
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        B_UTIL,
    input  logic        B_RW,
    inout  wire         B_BUS,
    output logic        B_ACK,
    output logic        S_BSY,
    output logic        S_WEN,
    output logic [11:0] S_WADDR,
    output logic [7:0]  S_WDATA
);

    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDRESS   = 3'd1,
        ST_ACKN      = 3'd2,
        ST_WRITE     = 3'd3,
        ST_READ      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [14:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [7:0]  wsh_q, wsh_d;
    logic [7:0]  rsh_q, rsh_d;
    logic        drv_q, drv_d;
    logic        ack_q, ack_d;
    logic        bsy_q, bsy_d;
    logic        wen_q, wen_d;
    logic [11:0] waddr_q, waddr_d;
    logic [7:0]  wdata_q, wdata_d;

    logic [7:0]  mem_q [MEM_DEPTH];
    logic        bus_in;

    assign bus_in = B_BUS;

    function automatic logic addr_hit(input logic [14:0] a);
        return (a[14:12] == SLAVE_ID) && ({20'd0, a[11:0]} < MEM_DEPTH);
    endfunction

    always_ff @(posedge CLK) begin
        if (RSTN) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 15'd0;
            rw_q    <= 1'b0;
            wsh_q   <= 8'd0;
            rsh_q   <= 8'd0;
            drv_q   <= 1'b0;
            ack_q   <= 1'b0;
            bsy_q   <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= 12'd0;
            wdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wsh_q   <= wsh_d;
            rsh_q   <= rsh_d;
            drv_q   <= drv_d;
            ack_q   <= ack_d;
            bsy_q   <= bsy_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // A dropped B_UTIL outranks every other transition in the active phases.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (B_UTIL) state_d = ST_ADDRESS;
            end
            ST_ADDRESS: begin
                if (!B_UTIL)              state_d = ST_IDLE;
                else if (cnt_q == 4'd13)  state_d = ST_ACKN;
            end
            ST_ACKN: begin
                if (!B_UTIL)              state_d = ST_IDLE;
                else if (addr_hit(addr_q)) state_d = rw_q ? ST_WRITE : ST_READ;
                else                      state_d = ST_WAIT_IDLE;
            end
            ST_WRITE, ST_READ: begin
                if (!B_UTIL)              state_d = ST_IDLE;
                else if (cnt_q == 4'd7)   state_d = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (!B_UTIL) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wsh_d   = wsh_q;
        rsh_d   = rsh_q;
        drv_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (B_UTIL) begin
                    addr_d = {bus_in, addr_q[14:1]};
                    rw_d   = B_RW;
                end
            end
            ST_ADDRESS: addr_d = {bus_in, addr_q[14:1]};
            ST_ACKN: begin
                if (state_d == ST_READ) begin
                    rsh_d = mem_q[addr_q[AW-1:0]];
                    drv_d = 1'b1;
                end
            end
            ST_WRITE: wsh_d = {bus_in, wsh_q[7:1]};
            ST_READ: begin
                rsh_d = {1'b0, rsh_q[7:1]};
                drv_d = (state_d == ST_READ);
            end
            default: ;
        endcase

        if (state_d != state_q)
            cnt_d = 4'd0;
        else if (state_q == ST_ADDRESS || state_q == ST_WRITE || state_q == ST_READ)
            cnt_d = cnt_q + 4'd1;

        // addr_d already holds addr[14] on the edge that enters ST_ACKN.
        ack_d = (state_d == ST_ACKN) && addr_hit(addr_d);
        bsy_d = (state_d != ST_IDLE);
        wen_d = (state_q == ST_WRITE) && (state_d == ST_WAIT_IDLE);
        if (wen_d) begin
            waddr_d = addr_q[11:0];
            wdata_d = wsh_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN && wen_d) mem_q[waddr_d[AW-1:0]] <= wdata_d;
    end

    assign B_BUS   = drv_q ? rsh_q[0] : 1'bz;
    assign B_ACK   = ack_q;
    assign S_BSY   = bsy_q;
    assign S_WEN   = wen_q;
    assign S_WADDR = waddr_q;
    assign S_WDATA = wdata_q;

endmodule

// File: tb/tb_bus_slave_port.sv
// Bench for bus_slave_port: directed scenarios plus randomized transactions,
// checked cycle by cycle against a transaction-level model of the slave.
module tb_bus_slave_port;

    logic        clk    = 1'b0;
    logic        rstn   = 1'b0;
    logic        b_util = 1'b0;
    logic        b_rw   = 1'b0;
    logic        tb_oe  = 1'b0;
    logic        tb_d   = 1'b0;
    wire         b_bus;
    logic        b_ack;
    logic        s_bsy;
    logic        s_wen;
    logic [11:0] s_waddr;
    logic [7:0]  s_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mdl_mem   [4096];
    bit         mdl_known [4096];
    logic [11:0] pool [8];

    assign b_bus = tb_oe ? tb_d : 1'bz;
    pullup pu_bus (b_bus);

    always #5 clk = ~clk;

    bus_slave_port #(.SLAVE_ID(3'd1), .MEM_DEPTH(2048)) dut (
        .CLK     (clk),
        .RSTN    (rstn),
        .B_UTIL  (b_util),
        .B_RW    (b_rw),
        .B_BUS   (b_bus),
        .B_ACK   (b_ack),
        .S_BSY   (s_bsy),
        .S_WEN   (s_wen),
        .S_WADDR (s_waddr),
        .S_WDATA (s_wdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // One master transaction: B_UTIL high for 'len' cycles (or until the reset
    // cycle rst_at), then low for 'gap' cycles. Cycle 0 carries addr[0].
    task automatic run_txn(input logic [14:0] addr, input logic rw, input logic [7:0] wdata,
                           input int len, input int gap, input int rst_at);
        int          hi, eff, total;
        logic [11:0] loc;
        logic [7:0]  rdata;
        bit          hit, rd_known, released, slave_drv, commit;
        logic        exp_bus;
        loc      = addr[11:0];
        hit      = (addr[14:12] == 3'd1) && (int'(loc) < 2048);
        hi       = (rst_at >= 0) ? rst_at + 1 : len;
        eff      = (rst_at >= 0) ? rst_at : len;
        total    = hi + gap;
        rdata    = mdl_mem[loc];
        rd_known = mdl_known[loc];
        commit   = hit && rw && (eff >= 24);
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            b_util   = (c < hi);
            b_rw     = rw;
            rstn     = (c == rst_at);
            released = 1'b1;
            tb_oe    = 1'b0;
            if (c < hi && c < 15) begin
                tb_oe = 1'b1; tb_d = addr[4'(c)]; released = 1'b0;
            end else if (c < hi && rw && c >= 16 && c <= 23) begin
                tb_oe = 1'b1; tb_d = wdata[3'(c - 16)]; released = 1'b0;
            end
            #1;
            check_eq($sformatf("bsy@%0d", c), 32'(s_bsy), 32'(c >= 1 && c <= eff));
            check_eq($sformatf("ack@%0d", c), 32'(b_ack), 32'(hit && c == 15 && eff >= 15));
            check_eq($sformatf("wen@%0d", c), 32'(s_wen), 32'(commit && c == 24));
            if (commit && c == 24) begin
                check_eq("waddr", 32'(s_waddr), 32'(loc));
                check_eq("wdata", 32'(s_wdata), 32'(wdata));
            end
            slave_drv = hit && !rw && c >= 16 && c <= 23 && eff >= c;
            exp_bus   = slave_drv ? rdata[3'(c - 16)] : 1'b1;
            if (released && !(slave_drv && !rd_known))
                check_eq($sformatf("bus@%0d", c), 32'(b_bus), 32'(exp_bus));
        end
        rstn = 1'b0;
        if (commit) begin
            mdl_mem[loc]   = wdata;
            mdl_known[loc] = 1'b1;
        end
    endtask

    initial begin
        logic [2:0]  id;
        logic [11:0] loc;
        logic        rw;
        int          len, gap, rst_at;

        rstn = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_ack",   32'(b_ack),   32'(0));
        check_eq("rst_bsy",   32'(s_bsy),   32'(0));
        check_eq("rst_wen",   32'(s_wen),   32'(0));
        check_eq("rst_waddr", 32'(s_waddr), 32'(0));
        check_eq("rst_wdata", 32'(s_wdata), 32'(0));
        check_eq("rst_bus",   32'(b_bus),   32'(1));
        @(negedge clk);
        rstn = 1'b0;

        // Basic write then read-back
        run_txn(15'h1005, 1'b1, 8'hA5, 24, 1, -1);
        run_txn(15'h1005, 1'b0, 8'h00, 24, 1, -1);
        // Wrong ID and out-of-range local address, held past the transaction length
        run_txn(15'h2005, 1'b0, 8'h00, 30, 1, -1);
        run_txn(15'h1800, 1'b0, 8'h00, 28, 1, -1);
        run_txn(15'h2005, 1'b1, 8'h77, 24, 1, -1);
        run_txn(15'h1005, 1'b1, 8'hA5, 24, 1, -1);
        // Abort after write data bit 4, then read-back of old value
        run_txn(15'h1005, 1'b1, 8'h3C, 21, 1, -1);
        run_txn(15'h1005, 1'b0, 8'h00, 24, 1, -1);
        // Reset during read data bit 3
        run_txn(15'h1005, 1'b0, 8'h00, 24, 2, 19);
        run_txn(15'h1005, 1'b0, 8'h00, 24, 1, -1);
        // Back-to-back writes, middle one out of range
        run_txn(15'h1000, 1'b1, 8'hFF, 24, 1, -1);
        run_txn(15'h1FFF, 1'b1, 8'h55, 24, 1, -1);
        run_txn(15'h17FF, 1'b1, 8'h01, 24, 1, -1);
        run_txn(15'h1000, 1'b0, 8'h00, 24, 1, -1);
        run_txn(15'h17FF, 1'b0, 8'h00, 24, 1, -1);
        // Abort during the ACK cycle and very early in the address phase
        run_txn(15'h1000, 1'b1, 8'h12, 15, 1, -1);
        run_txn(15'h1000, 1'b0, 8'h00, 3, 1, -1);
        run_txn(15'h1000, 1'b0, 8'h00, 24, 1, -1);

        for (int i = 0; i < 8; i++) begin
            pool[i] = 12'($urandom_range(0, 2047));
            run_txn({3'd1, pool[i]}, 1'b1, 8'($urandom), 24, 1, -1);
        end

        for (int i = 0; i < 40; i++) begin
            id  = ($urandom_range(0, 99) < 80) ? 3'd1 : 3'($urandom_range(0, 7));
            rw  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)
                loc = rw ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(2048, 4095));
            else
                loc = pool[$urandom_range(0, 7)];
            len    = ($urandom_range(0, 99) < 70) ? 24 + $urandom_range(0, 4) : $urandom_range(1, 23);
            gap    = $urandom_range(1, 3);
            rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 26) : -1;
            run_txn({id, loc}, rw, 8'($urandom), len, gap, rst_at);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
